stream_mux_rr: RTL and testbench

- Registered N:1 stream multiplexer with per-channel valid/ready handshake.
- Selects one of CHANNELS input streams, either by an external select (manual mode) or by a round-robin arbiter (auto mode).
- Presents the selected word through a single output register with channel tag.
- Sits between peripheral sources (switch/UART/counter streams) and a single consumer such as a display or TX path on the Basys3 designs.

---
 rtl/stream_mux_rr.sv | 147 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N:1 stream multiplexer.
// Selects one valid/ready input stream through either an external select or a
// round-robin arbiter. The chosen word goes into a single output register,
// which is tagged with the index of the channel that supplied it.
// The register reloads on the same cycle it drains, so it can carry one word
// per clock.
module stream_mux_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // The select range is a power of two. Valid bits above CHANNELS are padded
    // with zeros, so an out-of-range manual select never finds a valid channel.
    localparam int                SEL_SPAN   = 1 << SEL_W;
    localparam int                IDX_W      = SEL_W + 1;
    localparam logic [SEL_W-1:0]  LAST_CHAN  = SEL_W'(CHANNELS - 1);
    localparam logic [IDX_W-1:0]  CHAN_COUNT = IDX_W'(CHANNELS);

    // Output register and arbiter state
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_rr_ptr;

    // Combinational datapath / arbitration
    logic [WIDTH-1:0]    w_words [CHANNELS];
    logic [SEL_SPAN-1:0] w_valid_ext;
    logic                w_load_en;
    logic                w_man_found;
    logic                w_rr_found;
    logic [SEL_W-1:0]    w_rr_idx;
    logic [IDX_W-1:0]    w_rr_sum;
    logic                w_grant_valid;
    logic [SEL_W-1:0]    w_grant_idx;
    logic                w_xfer;
    logic [SEL_W-1:0]    w_ptr_next;

    // Unpack the flat input bus into one word per channel.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign w_words[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Widen the valid vector to cover every select code.
    generate
        if (SEL_SPAN == CHANNELS) begin : g_valid_full
            assign w_valid_ext = in_valid;
        end else begin : g_valid_pad
            assign w_valid_ext = {{(SEL_SPAN - CHANNELS){1'b0}}, in_valid};
        end
    endgenerate

    // The register can take a word when it is empty or draining this cycle.
    assign w_load_en   = ~r_out_valid | out_ready;

    // Manual grant: the selected channel must exist and be valid.
    assign w_man_found = w_valid_ext[sel];

    // Round-robin search starts at r_rr_ptr and wraps.
    // The scan runs from the farthest offset down to the nearest one, so the
    // nearest valid channel is written last and wins without needing a break.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_rr_sum   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            w_rr_sum = {1'b0, r_rr_ptr} + IDX_W'(i);
            if (w_rr_sum >= CHAN_COUNT) begin
                w_rr_sum = w_rr_sum - CHAN_COUNT;
            end
            if (in_valid[w_rr_sum[SEL_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_rr_sum[SEL_W-1:0];
            end
        end
    end

    // Choose between the manual grant and the round-robin grant.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        if (mode) begin
            w_grant_valid = w_rr_found;
            w_grant_idx   = w_rr_idx;
        end else begin
            w_grant_valid = w_man_found;
            w_grant_idx   = sel;
        end
    end

    // A transfer happens exactly when the granted channel sees ready.
    assign w_xfer     = w_grant_valid & w_load_en;

    // After a channel is served, the pointer moves to the channel after it.
    assign w_ptr_next = (w_grant_idx == LAST_CHAN) ? '0 : w_grant_idx + SEL_W'(1);

    // Drive ready one-hot to the granted channel, or to no channel at all.
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign in_ready[gi] = w_xfer & (w_grant_idx == SEL_W'(gi));
        end
    endgenerate

    // Output register: load on transfer, empty on a drain with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_words[w_grant_idx];
            r_out_chan  <= w_grant_idx;
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end
    end

    // Only round-robin transfers move the fairness pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer && mode) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized bench for stream_mux_rr.
// A 4-channel instance is checked against a rule-level reference model.
// A 3-channel instance exercises an out-of-range manual select.
module tb_stream_mux_rr;

    localparam int W   = 8;
    localparam int NCH = 4;
    localparam int SW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*W-1:0]  in_data;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic              mode;
    logic [SW-1:0]     sel;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_chan;
    logic              out_valid;
    logic              out_ready;

    logic [3*W-1:0]    d3_in_data;
    logic [2:0]        d3_in_valid;
    logic [2:0]        d3_in_ready;
    logic              d3_mode;
    logic [1:0]        d3_sel;
    logic [W-1:0]      d3_out_data;
    logic [1:0]        d3_out_chan;
    logic              d3_out_valid;
    logic              d3_out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic              m_valid;
    logic [W-1:0]      m_data;
    logic [SW-1:0]     m_chan;
    int                m_ptr;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .CHANNELS(NCH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux_rr #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d3_in_data),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .mode      (d3_mode),
        .sel       (d3_sel),
        .out_data  (d3_out_data),
        .out_chan  (d3_out_chan),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Grant computed from the arbitration rules; -1 means no channel is granted.
    function automatic int model_grant(input logic [NCH-1:0] v, input logic md,
                                       input logic [SW-1:0] s, input int ptr);
        if (!md) begin
            if (int'(s) < NCH && v[s]) return int'(s);
            return -1;
        end
        for (int i = 0; i < NCH; i++) begin
            int k;
            k = (ptr + i) % NCH;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // One clock: check the outputs, drive random inputs, check the ready
    // vector, then advance the model.
    // mode_pol: 0 manual, 1 round-robin, 2 random; sel_fix < 0 means random sel.
    task automatic run_cycle(input int vprob, input int rprob, input int mode_pol, input int sel_fix);
        int             g;
        logic           load;
        logic [NCH-1:0] exp_rdy;
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data",  32'(out_data),  32'(m_data));
        check_eq("out_chan",  32'(out_chan),  32'(m_chan));
        for (int k = 0; k < NCH; k++) begin
            in_valid[k]        = ($urandom_range(99) < vprob);
            in_data[k*W +: W]  = W'($urandom);
        end
        mode      = (mode_pol == 2) ? 1'($urandom_range(1)) : (mode_pol == 1);
        sel       = (sel_fix < 0) ? SW'($urandom_range(NCH - 1)) : SW'(sel_fix);
        out_ready = ($urandom_range(99) < rprob);
        if (out_valid && out_ready)
            $display("xfer chan=%0d data=%02h", out_chan, out_data);
        #1;
        load    = !m_valid || out_ready;
        g       = model_grant(in_valid, mode, sel, m_ptr);
        exp_rdy = (g >= 0 && load) ? NCH'(1 << g) : '0;
        check_eq("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (exp_rdy != '0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_chan  = SW'(g);
            if (mode) m_ptr = (g + 1) % NCH;
        end else if (load) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic run_phase(input int n, input int vprob, input int rprob, input int mode_pol, input int sel_fix);
        for (int i = 0; i < n; i++) run_cycle(vprob, rprob, mode_pol, sel_fix);
    endtask

    // Assert reset between clock edges while a word is held.
    task automatic mid_cycle_reset();
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(out_valid), 32'(m_valid));
        #2 rst = 1'b1;
        #1;
        check_eq("rst_async_valid", 32'(out_valid), 32'd0);
        check_eq("rst_async_data",  32'(out_data),  32'd0);
        check_eq("rst_async_chan",  32'(out_chan),  32'd0);
        m_valid = 1'b0; m_data = '0; m_chan = '0; m_ptr = 0;
        in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mode = 1'b1; in_valid = '1; out_ready = 1'b1;
        #1;
        check_eq("post_rst_grant", 32'(in_ready), 32'b0001);
        in_valid = '0;
    endtask

    initial begin
        rst = 1'b1;
        in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        d3_in_data = {8'hB2, 8'hB1, 8'hB0}; d3_in_valid = '0; d3_mode = 1'b0;
        d3_sel = '0; d3_out_ready = 1'b1;
        m_valid = 1'b0; m_data = '0; m_chan = '0; m_ptr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        check_eq("reset_data",  32'(out_data),  32'd0);
        check_eq("reset_chan",  32'(out_chan),  32'd0);
        rst = 1'b0;

        run_phase(10, 100, 100, 0, 2);   // manual sel=2, everything valid
        run_phase(12, 100, 100, 1, -1);  // round-robin fairness
        run_phase(20, 50, 100, 1, -1);   // sparse valids: skip and wrap
        run_phase(6, 100, 0, 1, -1);     // backpressure hold
        run_phase(4, 100, 100, 1, -1);   // drain and reload together
        run_phase(60, 60, 70, 2, -1);    // mixed modes and selects
        run_phase(2, 100, 100, 1, -1);   // ensure a word is held
        mid_cycle_reset();
        run_phase(8, 100, 100, 1, -1);
        run_phase(100, 40, 60, 2, -1);

        // 3-channel build: sel=3 selects no channel
        @(negedge clk);
        d3_mode = 1'b1; d3_in_valid = 3'b111; d3_sel = 2'd0;
        #1 check_eq("c3_rr_first", 32'(d3_in_ready), 32'b001);
        @(negedge clk);
        check_eq("c3_valid0", 32'(d3_out_valid), 32'd1);
        check_eq("c3_chan0",  32'(d3_out_chan),  32'd0);
        check_eq("c3_data0",  32'(d3_out_data),  32'hB0);
        d3_mode = 1'b0; d3_sel = 2'd3;
        #1 check_eq("c3_oor_ready", 32'(d3_in_ready), 32'd0);
        @(negedge clk);
        check_eq("c3_drained", 32'(d3_out_valid), 32'd0);
        check_eq("c3_oor_ready2", 32'(d3_in_ready), 32'd0);
        d3_mode = 1'b1;
        #1 check_eq("c3_rr_resume", 32'(d3_in_ready), 32'b010);
        @(negedge clk);
        check_eq("c3_valid1", 32'(d3_out_valid), 32'd1);
        check_eq("c3_chan1",  32'(d3_out_chan),  32'd1);
        check_eq("c3_data1",  32'(d3_out_data),  32'hB1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
